// File: rtl/ps2_kb_rx_if.sv
// PS/2 keyboard receiver bus.
//   ps2_clk, ps2_data : raw keyboard lines (asynchronous to the system clock)
//   sig_rd_kb         : pop strobe from the MMIO read path
//   kb_data           : scan code at the FIFO head (show-ahead)
//   kb_ready          : FIFO not empty
//   overflow          : sticky, a valid frame was dropped on a full FIFO
//   frame_err         : one-cycle pulse on parity / stop / timeout failure
// master = keyboard + CPU side, slave = receiver.
interface ps2_kb_rx_if #(
  parameter int KB_WIDTH = 8
);
  logic                ps2_clk;
  logic                ps2_data;
  logic                sig_rd_kb;
  logic [KB_WIDTH-1:0] kb_data;
  logic                kb_ready;
  logic                overflow;
  logic                frame_err;

  modport master (
    output ps2_clk, ps2_data, sig_rd_kb,
    input  kb_data, kb_ready, overflow, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data, sig_rd_kb,
    output kb_data, kb_ready, overflow, frame_err
  );
endinterface

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver with scan-code FIFO.
// Ports:
//   clk   : system clock, all state changes on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ps2_kb_rx_if slave (raw PS/2 lines in, FIFO head/flags out)
//
// state  | meaning
// IDLE   | waiting for a start bit (falling edge with data low)
// DATA   | shifting in data bits, LSB first
// PARITY | waiting for the parity bit
// STOP   | waiting for the stop bit; frame checked and pushed here
module ps2_kb_rx #(
  parameter int KB_WIDTH    = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  ps2_kb_rx_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(KB_WIDTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(KB_WIDTH - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic clk_s1_q, clk_s2_q, clk_s3_q, dat_s1_q, dat_s2_q;
  logic clk_s1_d, clk_s2_d, clk_s3_d, dat_s1_d, dat_s2_d;
  state_e              state_q, state_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [KB_WIDTH-1:0] shift_q, shift_d;
  logic                parity_q, parity_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                frame_err_q, frame_err_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [KB_WIDTH-1:0] mem [FIFO_DEPTH];

  logic ps2_fall, ps2_bit, push, pop, full, wr_en;

  always_comb begin
    clk_s1_d = bus.ps2_clk;
    clk_s2_d = clk_s1_q;
    clk_s3_d = clk_s2_q;
    dat_s1_d = bus.ps2_data;
    dat_s2_d = dat_s1_q;
  end

  assign ps2_fall = clk_s3_q & ~clk_s2_q;
  assign ps2_bit  = dat_s2_q;

  // Timeout is a down-counter reloaded on every PS/2 falling edge while a
  // frame is in flight; hitting zero with no edge abandons the frame.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tmo_d       = tmo_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    if (state_q == IDLE) begin
      if (ps2_fall && !ps2_bit) begin
        state_d   = DATA;
        bit_cnt_d = '0;
        tmo_d     = TMO_LOAD;
      end
    end else if (ps2_fall) begin
      tmo_d = TMO_LOAD;
      case (state_q)
        DATA: begin
          shift_d   = {ps2_bit, shift_q[KB_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) state_d = PARITY;
        end
        PARITY: begin
          parity_d = ps2_bit;
          state_d  = STOP;
        end
        default: begin
          state_d = IDLE;
          // Odd parity over data + parity bit, stop bit must be high.
          if (ps2_bit && (^{shift_q, parity_q})) push = 1'b1;
          else                                   frame_err_d = 1'b1;
        end
      endcase
    end else if (tmo_q == '0) begin
      state_d     = IDLE;
      shift_d     = '0;
      frame_err_d = 1'b1;
    end else begin
      tmo_d = tmo_q - TW'(1);
    end
  end

  // A pop frees a slot in the same cycle, so a push on a full FIFO with a
  // concurrent pop is still stored and does not count as an overflow.
  always_comb begin
    pop      = bus.sig_rd_kb && (count_q != '0);
    full     = (count_q == DEPTH_C);
    wr_en    = push && (!full || pop);
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !wr_en) count_d = count_q - (AW+1)'(1);
    overflow_d = overflow_q;
    if (pop)                  overflow_d = 1'b0;
    if (push && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_s3_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      clk_s3_q    <= clk_s3_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      frame_err_q <= frame_err_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage is not reset; kb_data is only meaningful while kb_ready is high.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= shift_q;
  end

  assign bus.kb_data   = mem[rd_ptr_q];
  assign bus.kb_ready  = (count_q != '0);
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: doc/ps2_kb_rx.md
PS2_KB_RX -- requirements
Module: ps2_kb_rx

Interface
REQ-001 Parameter KB_WIDTH, default 8, width of one received scan-code byte; only 8 is supported.
REQ-002 Parameter FIFO_DEPTH, default 8, number of scan-code entries buffered; power of two, at least 2.
REQ-003 Parameter TIMEOUT_CYC, default 5000, number of clk cycles without a PS/2 clock falling edge after which a partial frame is abandoned.
REQ-004 clk  input  1  system clock; all state changes on posedge clk.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-007 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-008 sig_rd_kb  input  1  pop strobe from the MMIO read path; one entry is consumed per cycle it is high.
REQ-009 kb_data  output  KB_WIDTH  scan code at the FIFO head (show-ahead).
REQ-010 kb_ready  output  1  FIFO is not empty.
REQ-011 overflow  output  1  sticky flag: a valid frame was dropped because the FIFO was full.
REQ-012 frame_err  output  1  one-cycle pulse when a frame fails parity, stop-bit or timeout checks.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a third ps2_clk flop SHALL detect a falling edge (prev=1, cur=0).
REQ-014 ps2_data SHALL be sampled from its synchronized value in the same cycle the falling edge is detected.
REQ-015 The FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-016 IDLE: on a falling edge, a sample of 0 SHALL move to DATA with the bit count at 0; a sample of 1 SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-017 DATA: each falling edge SHALL shift the sample in LSB-first; after the 8th bit the FSM SHALL move to PARITY.
REQ-018 PARITY: the falling edge SHALL capture the parity bit and move to STOP.
REQ-019 STOP: on the falling edge the FSM SHALL return to IDLE; the frame is valid only if the stop sample is 1 and the 8 data bits plus parity contain an odd number of ones.
REQ-020 Valid frame: the byte SHALL be pushed on the clk edge that processes the stop bit, and kb_ready SHALL be high in the following cycle.
REQ-021 Invalid frame: no push SHALL occur, and frame_err SHALL pulse for exactly one cycle.
REQ-022 Timeout: in DATA, PARITY or STOP, a counter SHALL reset on each falling edge; reaching TIMEOUT_CYC SHALL return the FSM to IDLE, discard the partial byte and pulse frame_err.
REQ-023 FIFO structure: circular buffer with rd_ptr and wr_ptr, each wrapping at FIFO_DEPTH, plus an occupancy count 0..FIFO_DEPTH.
REQ-024 FIFO flags: kb_ready = (count != 0); kb_data = mem[rd_ptr] combinationally.
REQ-025 Pop: sig_rd_kb while kb_ready SHALL advance rd_ptr; sig_rd_kb while empty SHALL be ignored, with no pointer or count change.
REQ-026 Push while full: a push with count == FIFO_DEPTH and no pop in the same cycle SHALL drop the byte and set overflow.
REQ-027 Push and pop in the same cycle: both SHALL take effect, count SHALL be unchanged, and when full the new byte SHALL be stored and overflow not set.
REQ-028 overflow SHALL clear on the first accepted pop after it was set; if a set and a clear coincide, the set wins.
REQ-029 Outputs SHALL be registered or derived from registers only, with no combinational path from ps2_* inputs to any output.

Reset
REQ-030 rst_n low SHALL immediately force: FSM to IDLE, bit count, timeout counter, rd_ptr, wr_ptr and count to 0, overflow, frame_err and kb_ready to 0, and synchronizer flops to 1 (PS/2 idle-high).
REQ-031 FIFO contents SHALL not be reset; kb_data is don't-care while kb_ready is 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; after release, only a complete new frame starting from a start bit SHALL be accepted.

Verification
REQ-033 Single frame: send 0x1C (start 0, data 0x1C, parity 0, stop 1) -> kb_ready=1, kb_data=0x1C, frame_err never pulses; sig_rd_kb for 1 cycle -> kb_ready=0.
REQ-034 Bad parity and bad stop: send 0xF0 with parity 0 (correct parity is 1) -> one frame_err pulse, kb_ready stays 0; send 0xF0 with stop 0 -> one frame_err pulse, no push.
REQ-035 Fill and overflow: send 9 valid bytes 0x01..0x09 with no reads -> overflow=1, then 8 pops return 0x01..0x08 in order, overflow clears after the first pop.
REQ-036 Simultaneous events: with the FIFO full, hold sig_rd_kb on the stop-bit cycle of 0x5A -> count stays 8, overflow=0, 0x5A is the last entry read; also sig_rd_kb while empty -> no state change.
REQ-037 Timeout: send start plus 4 data bits, then hold ps2_clk high for TIMEOUT_CYC cycles -> one frame_err pulse and FSM back in IDLE; a following 0x29 frame is received correctly.
REQ-038 Async reset: assert rst_n low mid-frame with 3 entries queued -> kb_ready=0 and overflow=0 immediately, with no clk edge needed.
